ssi_link_arbiter: RTL and testbench

- Owns the DB7 synchronous serial interface (SSI) and shares it between two requesters: the x86 PCI I/O decoder and the USB FTDI host path.
- Arbitrates between them round-robin, latches the winner's 8-bit register address and 16-bit data word, and serialises both onto SSAddr/SSDOut under a divided SSClock.
- Issues SSStrobe, then waits for SSAck with a timeout. Reports per-requester completion and a NoResponse status bit for the status register.

---
 rtl/ssi_link_arbiter_pkg.sv | 18 +
 rtl/ssi_link_arbiter_if.sv | 34 +++
 rtl/ssi_link_arbiter_shifter.sv | 70 +++++++
 rtl/ssi_link_arbiter.sv | 172 +++++++++++++++++
 tb/tb_ssi_link_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ssi_link_arbiter_pkg.sv
// rtl/ssi_link_arbiter_pkg.sv - shared types and constants for the DB7 SSI link arbiter
package ssi_link_arbiter_pkg;

  localparam int SSI_ADDR_BITS = 8;
  localparam int SSI_DATA_BITS = 16;

  localparam logic OWN_X86 = 1'b0;
  localparam logic OWN_USB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STROBE,
    WAIT_ACK,
    DONE
  } arb_state_t;

endpackage

// File: rtl/ssi_link_arbiter_if.sv
// rtl/ssi_link_arbiter_if.sv - requester handshakes and DB7 serial lines
interface ssi_link_arbiter_if;
  import ssi_link_arbiter_pkg::*;

  logic                     x86_Req;
  logic [SSI_ADDR_BITS-1:0] x86_Addr;
  logic [SSI_DATA_BITS-1:0] x86_Data;
  logic                     x86_Done;
  logic                     usb_Req;
  logic [SSI_ADDR_BITS-1:0] usb_Addr;
  logic [SSI_DATA_BITS-1:0] usb_Data;
  logic                     usb_Done;
  logic                     SSClock;
  logic                     SSAddr;
  logic                     SSDOut;
  logic                     SSStrobe;
  logic                     SSAck;
  logic                     Busy;
  logic                     Owner;
  logic                     NoResponse;

  // Requesters and the DB7 ack source sit on the master side.
  modport master (
    output x86_Req, x86_Addr, x86_Data, usb_Req, usb_Addr, usb_Data, SSAck,
    input  x86_Done, usb_Done, SSClock, SSAddr, SSDOut, SSStrobe, Busy, Owner, NoResponse
  );

  // The arbiter owns the serial lines and status.
  modport slave (
    input  x86_Req, x86_Addr, x86_Data, usb_Req, usb_Addr, usb_Data, SSAck,
    output x86_Done, usb_Done, SSClock, SSAddr, SSDOut, SSStrobe, Busy, Owner, NoResponse
  );

endinterface

// File: rtl/ssi_link_arbiter_shifter.sv
// rtl/ssi_link_arbiter_shifter.sv - SSClock divider and MSB-first address/data serialiser
module ssi_shifter
  import ssi_link_arbiter_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SSI_ADDR_BITS-1:0] addr,
  input  logic [SSI_DATA_BITS-1:0] data,
  output logic                     ss_clock,
  output logic                     ss_addr,
  output logic                     ss_dout,
  output logic                     shift_done
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(SSI_DATA_BITS);

  logic                     active;
  logic [DIV_W-1:0]         div;
  logic [BIT_W-1:0]         bit_cnt;
  logic [SSI_ADDR_BITS-1:0] addr_sr;
  logic [SSI_DATA_BITS-1:0] data_sr;
  logic                     period_end;

  // Lines come straight from the shift register MSBs; zero fill empties the
  // address after 8 periods and both registers after the last period.
  assign ss_addr    = addr_sr[SSI_ADDR_BITS-1];
  assign ss_dout    = data_sr[SSI_DATA_BITS-1];
  assign period_end = active && (div == DIV_W'(2 * CLK_DIV - 1));
  assign shift_done = period_end && (bit_cnt == BIT_W'(SSI_DATA_BITS - 1));

  // Divider, bit counter and shift registers; lines move only at period start.
  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      div      <= '0;
      bit_cnt  <= '0;
      addr_sr  <= '0;
      data_sr  <= '0;
      ss_clock <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      div      <= '0;
      bit_cnt  <= '0;
      addr_sr  <= addr;
      data_sr  <= data;
      ss_clock <= 1'b0;
    end else if (active) begin
      if (period_end) begin
        div      <= '0;
        ss_clock <= 1'b0;
        bit_cnt  <= bit_cnt + 1'b1;
        addr_sr  <= {addr_sr[SSI_ADDR_BITS-2:0], 1'b0};
        data_sr  <= {data_sr[SSI_DATA_BITS-2:0], 1'b0};
        if (bit_cnt == BIT_W'(SSI_DATA_BITS - 1)) begin
          active <= 1'b0;
        end
      end else begin
        div <= div + 1'b1;
        if (div == DIV_W'(CLK_DIV - 1)) begin
          ss_clock <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ssi_link_arbiter.sv
// rtl/ssi_link_arbiter.sv - round-robin owner of the DB7 SSI link for x86 and USB requesters
module ssi_link_arbiter #(
  parameter int CLK_DIV     = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                PCI_Clock,
  input  logic                PCI_Reset,
  ssi_link_arbiter_if.slave   bus
);
  import ssi_link_arbiter_pkg::*;

  localparam int STRB_W = $clog2(2 * CLK_DIV);
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [STRB_W-1:0] STRB_LAST = STRB_W'(2 * CLK_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TIMEOUT - 1);

  arb_state_t               state;
  logic                     owner;
  logic                     rr_ptr;
  logic                     busy;
  logic                     no_resp;
  logic                     strobe;
  logic                     x86_done;
  logic                     usb_done;
  logic                     ack_seen;
  logic [STRB_W-1:0]        strb_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     ack_s1;
  logic                     ack_s2;
  logic                     ack_prev;
  logic                     ack_rise;
  logic                     grant;
  logic                     win;
  logic                     start;
  logic [SSI_ADDR_BITS-1:0] win_addr;
  logic [SSI_DATA_BITS-1:0] win_data;
  logic                     sh_clock;
  logic                     sh_addr;
  logic                     sh_dout;
  logic                     shift_done;

  // Round-robin pick: a lone request wins outright, a tie goes to rr_ptr.
  always_comb begin
    grant = 1'b0;
    win   = OWN_X86;
    if (bus.x86_Req && bus.usb_Req) begin
      grant = 1'b1;
      win   = rr_ptr;
    end else if (bus.x86_Req) begin
      grant = 1'b1;
      win   = OWN_X86;
    end else if (bus.usb_Req) begin
      grant = 1'b1;
      win   = OWN_USB;
    end
  end

  assign start    = (state == IDLE) && grant;
  assign win_addr = (win == OWN_USB) ? bus.usb_Addr : bus.x86_Addr;
  assign win_data = (win == OWN_USB) ? bus.usb_Data : bus.x86_Data;
  assign ack_rise = ack_s2 && !ack_prev;

  ssi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk        (PCI_Clock),
    .rst        (PCI_Reset),
    .start      (start),
    .addr       (win_addr),
    .data       (win_data),
    .ss_clock   (sh_clock),
    .ss_addr    (sh_addr),
    .ss_dout    (sh_dout),
    .shift_done (shift_done)
  );

  // Two-flop synchroniser for the asynchronous ack, plus its previous value for edge detect.
  always_ff @(posedge PCI_Clock) begin
    if (PCI_Reset) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      ack_s1   <= bus.SSAck;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  // Transfer sequencer: grant, shift, strobe, wait for ack or timeout, report.
  always_ff @(posedge PCI_Clock) begin
    if (PCI_Reset) begin
      state    <= IDLE;
      owner    <= OWN_X86;
      rr_ptr   <= OWN_X86;
      busy     <= 1'b0;
      no_resp  <= 1'b0;
      strobe   <= 1'b0;
      x86_done <= 1'b0;
      usb_done <= 1'b0;
      ack_seen <= 1'b0;
      strb_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      x86_done <= 1'b0;
      usb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            owner    <= win;
            busy     <= 1'b1;
            no_resp  <= 1'b0;
            ack_seen <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            strobe   <= 1'b1;
            strb_cnt <= '0;
            state    <= STROBE;
          end
        end
        STROBE: begin
          if (ack_rise) begin
            ack_seen <= 1'b1;
          end
          if (strb_cnt == STRB_LAST) begin
            strobe  <= 1'b0;
            tmo_cnt <= '0;
            state   <= WAIT_ACK;
          end else begin
            strb_cnt <= strb_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (ack_rise || ack_seen) begin
            no_resp  <= 1'b0;
            x86_done <= (owner == OWN_X86);
            usb_done <= (owner == OWN_USB);
            state    <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            no_resp  <= 1'b1;
            x86_done <= (owner == OWN_X86);
            usb_done <= (owner == OWN_USB);
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          rr_ptr <= ~owner;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SSClock    = sh_clock;
  assign bus.SSAddr     = sh_addr;
  assign bus.SSDOut     = sh_dout;
  assign bus.SSStrobe   = strobe;
  assign bus.Busy       = busy;
  assign bus.Owner      = owner;
  assign bus.NoResponse = no_resp;
  assign bus.x86_Done   = x86_done;
  assign bus.usb_Done   = usb_done;

endmodule

// File: tb/tb_ssi_link_arbiter.sv
// tb/tb_ssi_link_arbiter.sv - directed self-checking bench for ssi_link_arbiter
module tb_ssi_link_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ssi_link_arbiter_if bus();

  ssi_link_arbiter #(
    .CLK_DIV     (4),
    .ACK_TIMEOUT (64)
  ) dut (
    .PCI_Clock (clk),
    .PCI_Reset (rst),
    .bus       (bus)
  );

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.SSClock, bus.SSAddr, bus.SSDOut, bus.SSStrobe, bus.Busy,
            bus.Owner, bus.x86_Done, bus.usb_Done, bus.NoResponse};
  endfunction

  // Follows one transfer from its first SHIFT cycle to the cycle after Done.
  task automatic xfer(input int ack_dly, input int chg_at,
                      output logic [15:0] dcap, output logic [15:0] acap,
                      output int nrise, output int slen, output int dlat,
                      output logic xd, output logic ud, output logic own,
                      output logic nr, output logic pd, output logic pb);
    logic prev_clk;
    logic strobe_seen;
    int   wlen;
    bit   fin;
    dcap = '0; acap = '0; nrise = 0; slen = 0; dlat = -1;
    xd = 1'b0; ud = 1'b0; own = 1'b0; nr = 1'b0;
    prev_clk = 1'b0; strobe_seen = 1'b0; wlen = 0; fin = 1'b0;
    for (int n = 0; n < 2000 && !fin; n++) begin
      @(negedge clk);
      if (n == chg_at) begin
        bus.usb_Req  = 1'b0;
        bus.usb_Data = 16'hFFFF;
        bus.usb_Addr = 8'hFF;
      end
      if (bus.SSClock && !prev_clk) begin
        dcap = {dcap[14:0], bus.SSDOut};
        acap = {acap[14:0], bus.SSAddr};
        nrise++;
      end
      prev_clk = bus.SSClock;
      if (bus.SSStrobe) begin
        slen++;
        strobe_seen = 1'b1;
      end else if (strobe_seen) begin
        if (ack_dly >= 0 && wlen == ack_dly)     bus.SSAck = 1'b1;
        if (ack_dly >= 0 && wlen == ack_dly + 2) bus.SSAck = 1'b0;
        wlen++;
      end
      if (bus.x86_Done || bus.usb_Done) begin
        xd   = bus.x86_Done;
        ud   = bus.usb_Done;
        own  = bus.Owner;
        nr   = bus.NoResponse;
        dlat = wlen - 1;
        fin  = 1'b1;
      end
    end
    if (ack_dly >= 0) bus.SSAck = 1'b0;
    @(negedge clk);
    pd = bus.x86_Done | bus.usb_Done;
    pb = bus.Busy;
  endtask

  logic [15:0] dcap, acap;
  int          nrise, slen, dlat;
  logic        xd, ud, own, nr, pd, pb;
  logic        exp_own;
  logic        seen;

  initial begin
    rst = 1'b0;
    bus.x86_Req = 1'b0; bus.x86_Addr = 8'h00; bus.x86_Data = 16'h0000;
    bus.usb_Req = 1'b0; bus.usb_Addr = 8'h00; bus.usb_Data = 16'h0000;
    bus.SSAck   = 1'b0;

    // Reset state
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("reset_outs", outs(), 9'h000);
    rst = 1'b0;
    @(negedge clk);

    // Single x86 transfer, ack 5 cycles into WAIT_ACK
    bus.x86_Addr = 8'hA5; bus.x86_Data = 16'h1234; bus.x86_Req = 1'b1;
    xfer(5, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    bus.x86_Req = 1'b0;
    check("t1_rises", nrise, 16);
    check("t1_sdout", dcap, 16'h1234);
    check("t1_saddr", acap, 16'hA500);
    check("t1_strobe_len", slen, 8);
    check("t1_done_lat", dlat, 8);
    check("t1_done_pair", {xd, ud}, 2'b10);
    check("t1_owner", own, 1'b0);
    check("t1_noresp", nr, 1'b0);
    check("t1_done_once", pd, 1'b0);
    check("t1_busy_drop", pb, 1'b0);

    // Both requesters from reset, held: x86, USB, x86, USB
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    bus.x86_Addr = 8'h5A; bus.x86_Data = 16'hC0DE;
    bus.usb_Addr = 8'h3C; bus.usb_Data = 16'hBEEF;
    bus.x86_Req = 1'b1; bus.usb_Req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      xfer(0, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
      exp_own = (i % 2 == 1);
      check($sformatf("t2_owner%0d", i), own, exp_own);
      check($sformatf("t2_done%0d", i), {xd, ud}, exp_own ? 2'b01 : 2'b10);
      check($sformatf("t2_data%0d", i), dcap, exp_own ? 16'hBEEF : 16'hC0DE);
      check($sformatf("t2_addr%0d", i), acap, exp_own ? 16'h3C00 : 16'h5A00);
      if (i == 3) begin
        bus.x86_Req = 1'b0; bus.usb_Req = 1'b0;
      end
    end

    // No ack: timeout 64 cycles after WAIT_ACK entry, sticky NoResponse
    bus.x86_Req = 1'b1;
    xfer(-1, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    bus.x86_Req = 1'b0;
    check("t3_done_lat", dlat, 64);
    check("t3_noresp", nr, 1'b1);
    check("t3_done_pair", {xd, ud}, 2'b10);
    repeat (10) @(negedge clk);
    check("t3_noresp_hold", bus.NoResponse, 1'b1);
    bus.usb_Addr = 8'h11; bus.usb_Data = 16'h2222; bus.usb_Req = 1'b1;
    @(negedge clk);
    check("t3_grant_clears", {bus.NoResponse, bus.Busy, bus.Owner}, 3'b011);
    xfer(2, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    bus.usb_Req = 1'b0;
    check("t3_usb_done", {xd, ud, nr}, 3'b010);
    check("t3_usb_data", dcap, 16'h2222);

    // Stale high ack level never counts
    bus.SSAck = 1'b1;
    repeat (5) @(negedge clk);
    bus.x86_Req = 1'b1;
    xfer(-1, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    bus.x86_Req = 1'b0;
    bus.SSAck = 1'b0;
    check("t4_done_lat", dlat, 64);
    check("t4_noresp", nr, 1'b1);

    // Reset in the middle of SHIFT (period 7)
    repeat (3) @(negedge clk);
    bus.x86_Addr = 8'h96; bus.x86_Data = 16'h0F0F; bus.x86_Req = 1'b1;
    repeat (59) @(negedge clk);
    check("t5_busy_mid", bus.Busy, 1'b1);
    rst = 1'b1; bus.x86_Req = 1'b0;
    @(negedge clk);
    check("t5_reset_outs", outs(), 9'h000);
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | bus.x86_Done | bus.usb_Done | bus.Busy;
    end
    check("t5_quiet", seen, 1'b0);
    bus.usb_Addr = 8'h44; bus.usb_Data = 16'h7777;
    bus.x86_Req = 1'b1; bus.usb_Req = 1'b1;
    xfer(0, -1, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    bus.x86_Req = 1'b0; bus.usb_Req = 1'b0;
    check("t5_x86_first", {xd, ud, own}, 3'b100);
    check("t5_data", dcap, 16'h0F0F);
    check("t5_addr", acap, 16'h9600);

    // USB drops Req and changes data mid-SHIFT
    repeat (2) @(negedge clk);
    bus.usb_Addr = 8'h81; bus.usb_Data = 16'h5AC3; bus.usb_Req = 1'b1;
    xfer(1, 20, dcap, acap, nrise, slen, dlat, xd, ud, own, nr, pd, pb);
    check("t6_data", dcap, 16'h5AC3);
    check("t6_addr", acap, 16'h8100);
    check("t6_done_pair", {xd, ud, own}, 3'b011);
    check("t6_done_once", pd, 1'b0);
    repeat (5) @(negedge clk);
    check("t6_idle", {bus.Busy, bus.usb_Done}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
